// File: rtl/t06_display_pkg.sv
// Shared encodings, ASCII constants and fixed words for the LCD status formatter.
package t06_display_pkg;

  typedef enum logic [1:0] {GS_RUN = 2'b00, GS_WAIT = 2'b01, GS_PAUSE = 2'b10, GS_END = 2'b11} game_state_e;
  typedef enum logic [1:0] {GM_2APP = 2'b00, GM_NORM = 2'b01, GM_WALL = 2'b10, GM_BORD = 2'b11} game_mode_e;
  typedef enum logic [1:0] {AL_NORMAL = 2'b00, AL_LUCKY = 2'b01, AL_UNLUCKY = 2'b10, AL_BLANK = 2'b11} apple_luck_e;
  typedef enum logic [1:0] {SP_NORM = 2'b00, SP_FAST = 2'b01, SP_SLOW = 2'b10, SP_BLANK = 2'b11} game_speed_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [39:0] W_RUN     = "RUN  ";
  localparam logic [39:0] W_WAIT    = "WAIT ";
  localparam logic [39:0] W_PAUSE   = "PAUSE";
  localparam logic [39:0] W_END     = "END  ";
  localparam logic [39:0] W_SPD     = "SPD: ";
  localparam logic [31:0] W_2APP    = "2APP";
  localparam logic [31:0] W_NORM    = "NORM";
  localparam logic [31:0] W_WALL    = "WALL";
  localparam logic [31:0] W_BORD    = "BORD";
  localparam logic [31:0] W_FAST    = "FAST";
  localparam logic [31:0] W_SLOW    = "SLOW";
  localparam logic [31:0] W_BLANK4  = "    ";
  localparam logic [55:0] W_NORMAL  = "NORMAL ";
  localparam logic [55:0] W_LUCKY   = "LUCKY  ";
  localparam logic [55:0] W_UNLUCKY = "UNLUCKY";
  localparam logic [55:0] W_BLANK7  = "       ";

  // Column c of a 16-character row occupies bits [col_msb(c) -: 8].
  function automatic int col_msb(input int col);
    return 127 - 8 * col;
  endfunction

  function automatic logic [39:0] state_word(input logic [1:0] s);
    case (s)
      GS_RUN:   return W_RUN;
      GS_WAIT:  return W_WAIT;
      GS_PAUSE: return W_PAUSE;
      default:  return W_END;
    endcase
  endfunction

  function automatic logic [31:0] mode_word(input logic [1:0] m);
    case (m)
      GM_2APP: return W_2APP;
      GM_NORM: return W_NORM;
      GM_WALL: return W_WALL;
      default: return W_BORD;
    endcase
  endfunction

  function automatic logic [55:0] luck_word(input logic [1:0] l);
    case (l)
      AL_NORMAL:  return W_NORMAL;
      AL_LUCKY:   return W_LUCKY;
      AL_UNLUCKY: return W_UNLUCKY;
      default:    return W_BLANK7;
    endcase
  endfunction

  function automatic logic [31:0] speed_word(input logic [1:0] s);
    case (s)
      SP_NORM: return W_NORM;
      SP_FAST: return W_FAST;
      SP_SLOW: return W_SLOW;
      default: return W_BLANK4;
    endcase
  endfunction

endpackage

// File: rtl/t06_bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, done pulses SCORE_W cycles after start.
module t06_bin2bcd_seq #(
  parameter int SCORE_W = 8,
  parameter int DIGITS  = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [SCORE_W-1:0]  bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] sh_q, sh_d;
  logic [BW-1:0]      bcd_q, bcd_d, adj;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, bad_digit;

  // Add-3 correction of every nibble >= 5, plus detection of non-decimal nibbles.
  always_comb begin
    adj       = bcd_q;
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      if (bcd_q[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Step sequencing; a 1 leaving the top of the BCD field latches overflow.
  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (start) begin
      sh_d   = bin;
      bcd_d  = '0;
      cnt_d  = CW'(SCORE_W);
      busy_d = 1'b1;
      ovf_d  = 1'b0;
    end else if (busy_q) begin
      bcd_d = {adj[BW-2:0], sh_q[SCORE_W-1]};
      sh_d  = {sh_q[SCORE_W-2:0], 1'b0};
      ovf_d = ovf_q | adj[BW-1];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Converter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q | bad_digit;

endmodule

// File: rtl/t06_lcd_status_fmt.sv
// Snapshots game status, converts the score to BCD and publishes 16x2 text frames.
//   state  | meaning
//   IDLE   | compare live inputs to snapshot, wait for a refresh reason
//   CONV   | BCD conversion of the snapshot score in progress
//   FMT    | row registers loaded from snapshot and BCD result
//   PUB    | frame offered with upd_valid, rows frozen until accepted
module t06_lcd_status_fmt #(
  parameter int SCORE_W   = 8,
  parameter int DIGITS    = 3,
  parameter int SCORE_COL = 6,
  parameter int BLINK_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [1:0]         gameState,
  input  logic [1:0]         gameMode,
  input  logic [1:0]         appleLuck,
  input  logic [1:0]         gameSpeed,
  input  logic [SCORE_W-1:0] score,
  input  logic               force_refresh,
  output logic [127:0]       row_top,
  output logic [127:0]       row_bot,
  output logic               upd_valid,
  input  logic               upd_ready
);
  import t06_display_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0, S_CONV = 2'd1, S_FMT = 2'd2, S_PUB = 2'd3;
  localparam int BCW = $clog2(BLINK_CYC);

  logic [1:0]          fsm_q, fsm_d;
  logic [1:0]          snap_state_q, snap_state_d, snap_mode_q, snap_mode_d;
  logic [1:0]          snap_luck_q, snap_luck_d, snap_speed_q, snap_speed_d;
  logic [SCORE_W-1:0]  snap_score_q, snap_score_d;
  logic                snap_blank_q, snap_blank_d;
  logic                pending_q, pending_d, blank_q, blank_d, valid_q, valid_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [127:0]        row_top_q, row_top_d, row_bot_q, row_bot_d, top_fmt, bot_fmt;
  logic                paused, blink_tog, live_diff, load, bcd_start, bcd_busy, bcd_done, bcd_ovf;
  logic [4*DIGITS-1:0] bcd_val;
  logic [3:0]          nib;
  logic                lead;

  t06_bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk),
    .nrst  (nrst),
    .start (bcd_start),
    .bin   (score),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_val),
    .ovf   (bcd_ovf)
  );

  assign paused    = (snap_state_q == GS_PAUSE);
  assign blink_tog = paused && (bcnt_q == BCW'(BLINK_CYC - 1));
  assign live_diff = (gameState != snap_state_q) || (gameMode != snap_mode_q) ||
                     (appleLuck != snap_luck_q) || (gameSpeed != snap_speed_q) ||
                     (score != snap_score_q) || (blank_q != snap_blank_q);
  assign load      = (fsm_q == S_IDLE) && !bcd_busy &&
                     (pending_q || live_diff || force_refresh || blink_tog);

  // Blink timer and phase; a snapshot that leaves PAUSE restarts both at the same edge.
  always_comb begin
    bcnt_d  = bcnt_q;
    blank_d = blank_q;
    if (!paused) begin
      bcnt_d  = '0;
      blank_d = 1'b0;
    end else if (blink_tog) begin
      bcnt_d  = '0;
      blank_d = ~blank_q;
    end else begin
      bcnt_d = bcnt_q + BCW'(1);
    end
    if (load && (gameState != GS_PAUSE)) begin
      bcnt_d  = '0;
      blank_d = 1'b0;
    end
  end

  // Snapshot capture and the pending flag for refresh requests seen mid-frame.
  always_comb begin
    snap_state_d = snap_state_q;
    snap_mode_d  = snap_mode_q;
    snap_luck_d  = snap_luck_q;
    snap_speed_d = snap_speed_q;
    snap_score_d = snap_score_q;
    snap_blank_d = snap_blank_q;
    pending_d    = pending_q;
    if (load) begin
      snap_state_d = gameState;
      snap_mode_d  = gameMode;
      snap_luck_d  = appleLuck;
      snap_speed_d = gameSpeed;
      snap_score_d = score;
      snap_blank_d = blank_d;
      pending_d    = 1'b0;
    end else if (force_refresh || blink_tog) begin
      pending_d = 1'b1;
    end
  end

  // Row text built from the snapshot and the finished BCD value.
  always_comb begin
    top_fmt = {16{ASCII_SPACE}};
    if (!(paused && snap_blank_q)) top_fmt[col_msb(0) -: 40] = state_word(snap_state_q);
    lead = 1'b1;
    nib  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd_val[4*(DIGITS-1-i) +: 4];
      if ((nib != 4'd0) || (i == DIGITS - 1)) lead = 1'b0;
      if (bcd_ovf) top_fmt[col_msb(SCORE_COL + i) -: 8] = ASCII_ZERO | 8'h09;
      else if (!lead) top_fmt[col_msb(SCORE_COL + i) -: 8] = ASCII_ZERO | {4'h0, nib};
    end
    top_fmt[col_msb(12) -: 32] = mode_word(snap_mode_q);
    bot_fmt = {luck_word(snap_luck_q), W_SPD, speed_word(snap_speed_q)};
  end

  // Frame sequencing and handshake.
  always_comb begin
    fsm_d     = fsm_q;
    valid_d   = valid_q;
    row_top_d = row_top_q;
    row_bot_d = row_bot_q;
    bcd_start = 1'b0;
    case (fsm_q)
      S_IDLE: if (load) begin
        bcd_start = 1'b1;
        fsm_d     = S_CONV;
      end
      S_CONV: if (bcd_done) fsm_d = S_FMT;
      S_FMT: begin
        row_top_d = top_fmt;
        row_bot_d = bot_fmt;
        valid_d   = 1'b1;
        fsm_d     = S_PUB;
      end
      S_PUB: if (upd_ready) begin
        valid_d = 1'b0;
        fsm_d   = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm_q        <= S_IDLE;
      snap_state_q <= '0;
      snap_mode_q  <= '0;
      snap_luck_q  <= '0;
      snap_speed_q <= '0;
      snap_score_q <= '0;
      snap_blank_q <= 1'b0;
      pending_q    <= 1'b1;
      blank_q      <= 1'b0;
      bcnt_q       <= '0;
      valid_q      <= 1'b0;
      row_top_q    <= {16{ASCII_SPACE}};
      row_bot_q    <= {16{ASCII_SPACE}};
    end else begin
      fsm_q        <= fsm_d;
      snap_state_q <= snap_state_d;
      snap_mode_q  <= snap_mode_d;
      snap_luck_q  <= snap_luck_d;
      snap_speed_q <= snap_speed_d;
      snap_score_q <= snap_score_d;
      snap_blank_q <= snap_blank_d;
      pending_q    <= pending_d;
      blank_q      <= blank_d;
      bcnt_q       <= bcnt_d;
      valid_q      <= valid_d;
      row_top_q    <= row_top_d;
      row_bot_q    <= row_bot_d;
    end
  end

  assign row_top   = row_top_q;
  assign row_bot   = row_bot_q;
  assign upd_valid = valid_q;

endmodule
